// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph blitter: FSM state encoding,
// default geometry, and the helpers that turn geometry into the derived
// text-grid limits and address line step.
package glyph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_SCREEN_H = 480;
    localparam int unsigned DEF_CHAR_W   = 20;
    localparam int unsigned DEF_CHAR_H   = 30;
    localparam int unsigned DEF_ORIGIN_Y = 270;

    function automatic int unsigned max_cols(input int unsigned sw, input int unsigned cw);
        return sw / cw;
    endfunction

    function automatic int unsigned max_rows(input int unsigned sh, input int unsigned oy,
                                             input int unsigned ch);
        return (sh - oy) / ch;
    endfunction

    function automatic int unsigned line_step(input int unsigned sw, input int unsigned cw);
        return sw - cw + 1;
    endfunction

    localparam int unsigned MAX_COLS  = max_cols(DEF_SCREEN_W, DEF_CHAR_W);
    localparam int unsigned MAX_ROWS  = max_rows(DEF_SCREEN_H, DEF_ORIGIN_Y, DEF_CHAR_H);
    localparam int unsigned CELL_PIX  = DEF_CHAR_W * DEF_CHAR_H;
    localparam int unsigned LINE_STEP = line_step(DEF_SCREEN_W, DEF_CHAR_W);

endpackage

// File: rtl/glyph_blitter_if.sv
// Request, glyph ROM and framebuffer write signals of the glyph blitter.
// master = front end / ROM / framebuffer side, slave = the blitter.
interface glyph_blitter_if #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned GLYPH_BITS = 600
);
    logic                  req_valid;
    logic                  req_ready;
    logic [7:0]            req_row;
    logic [7:0]            req_col;
    logic [CODE_W-1:0]     req_char;
    logic [COLOR_W-1:0]    req_fg;
    logic [COLOR_W-1:0]    req_bg;
    logic                  req_clear;
    logic                  req_err;
    logic                  done;
    logic [CODE_W-1:0]     glyph_addr;
    logic [GLYPH_BITS-1:0] glyph_bits;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [COLOR_W-1:0]    mem_wdata;
    logic                  mem_wenable;

    modport master (
        output req_valid, req_row, req_col, req_char, req_fg, req_bg, req_clear, glyph_bits,
        input  req_ready, req_err, done, glyph_addr, mem_waddr, mem_wdata, mem_wenable
    );

    modport slave (
        input  req_valid, req_row, req_col, req_char, req_fg, req_bg, req_clear, glyph_bits,
        output req_ready, req_err, done, glyph_addr, mem_waddr, mem_wdata, mem_wenable
    );
endinterface

// File: rtl/glyph_addr_gen.sv
// Cell address generator: loads the cell base address, then walks the cell
// in raster order one pixel per step, flagging the final pixel of the cell.
module glyph_addr_gen import glyph_pkg::*; #(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned CHAR_W   = DEF_CHAR_W,
    parameter int unsigned CHAR_H   = DEF_CHAR_H
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              cell_end_o
);
    localparam int unsigned XW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int unsigned YW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
    localparam logic [ADDR_W-1:0] STEP_LINE = ADDR_W'(line_step(SCREEN_W, CHAR_W));

    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              line_end;

    assign line_end   = (x_q == XW'(CHAR_W - 1));
    assign cell_end_o = line_end && (y_q == YW'(CHAR_H - 1));
    assign addr_o     = addr_q;

    // Position/address register: +1 within a line, jump to next line start at line end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (load_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= base_i;
        end else if (step_i) begin
            if (line_end) begin
                x_q    <= '0;
                y_q    <= y_q + 1'b1;
                addr_q <= addr_q + STEP_LINE;
            end else begin
                x_q    <= x_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/glyph_blitter.sv
// Glyph blitter: accepts one character-cell request, fetches its bitmap from
// the external glyph ROM and writes the cell into the framebuffer one pixel
// per clock. Optional macro TRANSPARENT_BG_EN: clear glyph bits are skipped
// (no write strobe) unless the request is a clear-cell fill.
module glyph_blitter import glyph_pkg::*; #(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter int unsigned CHAR_W   = DEF_CHAR_W,
    parameter int unsigned CHAR_H   = DEF_CHAR_H,
    parameter int unsigned ORIGIN_Y = DEF_ORIGIN_Y,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned CODE_W   = 8
) (
    input  logic           clock,
    input  logic           reset,
    glyph_blitter_if.slave bus
);
    localparam int unsigned PIX = CHAR_W * CHAR_H;
    localparam int unsigned BW  = ADDR_W + 4;
    localparam logic [7:0] MAX_COLS_C = 8'(max_cols(SCREEN_W, CHAR_W));
    localparam logic [7:0] MAX_ROWS_C = 8'(max_rows(SCREEN_H, ORIGIN_Y, CHAR_H));

    state_t             state_q, state_d;
    logic               cap_q;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [CODE_W-1:0]  glyph_addr_q;
    logic [7:0]         row_q, col_q;
    logic [COLOR_W-1:0] fg_q, bg_q;
    logic               clear_q;
    logic [PIX-1:0]     shift_q;

    logic               accept, in_range;
    logic               load, step, draw_pix, cell_end;
    logic [ADDR_W-1:0]  base, addr;

    assign accept   = bus.req_valid && (state_q == ST_IDLE);
    assign in_range = (bus.req_col < MAX_COLS_C) && (bus.req_row < MAX_ROWS_C);
    assign base     = ADDR_W'((BW'(ORIGIN_Y) + BW'(row_q) * BW'(CHAR_H)) * BW'(SCREEN_W)
                              + BW'(col_q) * BW'(CHAR_W));

    glyph_addr_gen #(
        .ADDR_W  (ADDR_W),
        .SCREEN_W(SCREEN_W),
        .CHAR_W  (CHAR_W),
        .CHAR_H  (CHAR_H)
    ) u_addr_gen (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (load),
        .base_i    (base),
        .step_i    (step),
        .addr_o    (addr),
        .cell_end_o(cell_end)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle controls; the first DRAW cycle waits for ROM capture.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        draw_pix = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_range) state_d = ST_FETCH;
                    else          err_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                load    = 1'b1;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (!cap_q) begin
                    draw_pix = 1'b1;
                    step     = 1'b1;
                    if (cell_end) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, glyph shift register and pulse outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_q        <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            glyph_addr_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            clear_q      <= 1'b0;
            shift_q      <= '0;
        end else begin
            cap_q  <= load;
            err_q  <= err_d;
            done_q <= done_d;
            if (accept) begin
                glyph_addr_q <= bus.req_char;
                row_q        <= bus.req_row;
                col_q        <= bus.req_col;
                fg_q         <= bus.req_fg;
                bg_q         <= bus.req_bg;
                clear_q      <= bus.req_clear;
            end
            if (cap_q)     shift_q <= bus.glyph_bits;
            else if (step) shift_q <= shift_q >> 1;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.req_err    = err_q;
    assign bus.done       = done_q;
    assign bus.glyph_addr = glyph_addr_q;
    assign bus.mem_waddr  = addr;
    assign bus.mem_wdata  = (clear_q || !shift_q[0]) ? bg_q : fg_q;
`ifdef TRANSPARENT_BG_EN
    assign bus.mem_wenable = draw_pix && (clear_q || shift_q[0]);
`else
    assign bus.mem_wenable = draw_pix;
`endif
endmodule
